bus_arbiter_2m: RTL and testbench
=================================

# bus_arbiter_2m

Two-master round-robin arbiter in front of `bus_interface_2`. It shares the single CPU-side memory bus between master 0 (CPU core) and master 1 (DMA/boot loader). It holds each grant until completion and inserts a mandatory idle cycle between transactions. It also terminates accesses to unmapped addresses with a timeout and error response.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles in BUSY without `mem_ready` before forced error completion (2..255).
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on timeout.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `m0_valid`, `m1_valid` in 1: request from master N; held high until `mN_ready`.
- `m0_instr`, `m1_instr` in 1: fetch qualifier.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wstrb`, `m1_wstrb` in 4: byte write strobes; 0 = read.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_ready`, `m1_ready` out 1: one-cycle completion pulse to master N.
- `m0_rdata`, `m1_rdata` out 32: read data, valid while `mN_ready`.
- `mem_valid`, `mem_instr`, `mem_addr[31:0]`, `mem_wstrb[3:0]`, `mem_wdata[31:0]` out: downstream request.
- `mem_ready` in 1, `mem_rdata` in 32: downstream completion.
- `grant` out 1: index of the current/last granted master.
- `bus_err` out 1: sticky timeout flag.
- `err_addr` out 32: address of first timed-out access since clear.
- `err_clr` in 1: synchronous clear of `bus_err`/`err_addr`.

## Operation
- States: IDLE, BUSY, GAP. Reset enters IDLE with `grant`=1, so master 0 wins the first tie.
- IDLE: if any `mN_valid`, latch the winner into `grant` and go to BUSY.
  - Round-robin: on a tie the master not equal to the current `grant` wins; a single requester always wins.
- BUSY: `mem_valid`=1; `mem_*` request fields are driven combinationally from the granted master. Timeout counter increments each cycle.
  - `mem_ready`=1: pulse `m[grant]_ready` with `m[grant]_rdata`=`mem_rdata`, then go to GAP.
  - Counter reaches `TIMEOUT_CYCLES`-1 without `mem_ready`: pulse `m[grant]_ready` with rdata=`ERR_RDATA`, then go to GAP.
    - Set `bus_err`. Capture the address in `err_addr` only if `bus_err` was 0.
  - Writes and reads are handled identically.
- GAP: one cycle, `mem_valid`=0. Any `mem_ready` here or in IDLE is ignored. The downstream registered ready from the previous valid cycle is absorbed here. Next state is always IDLE.
- Non-granted master: `ready`=0. `rdata` holds its last returned value (registered per master, reset 0).
- Request fields (`mem_addr`, etc.) are 0 when `mem_valid`=0.
- `err_clr` and a timeout in the same cycle: the timeout wins (`bus_err` stays 1, `err_addr` is loaded).
- A master dropping `valid` mid-BUSY is a protocol violation. The arbiter still completes the transaction and does not re-arbitrate.

## Timing
- Reset values: `mem_valid`=0, all `mem_*` outputs 0, `m0/m1_ready`=0, `m0/m1_rdata`=0, `grant`=1, `bus_err`=0, `err_addr`=0, counter 0.
- Async reset mid-BUSY: all outputs return to reset values immediately; the pending transaction is abandoned without a ready pulse.
- Arbitration latency: `valid` seen in cycle T means `mem_valid` is high from T+1.
- RAM/ROM access (`mem_ready` at T+2) gives `mN_ready` at T+2 (combinational pass-through), GAP at T+3, and the next IDLE decision at T+4.
- Peak throughput: one transaction per 4 cycles for a registered-ready slave, or per 3 cycles for a combinational-ready slave.
- Timeout: `mN_ready` occurs exactly `TIMEOUT_CYCLES` cycles after BUSY entry (T+1 .. T+`TIMEOUT_CYCLES`).
- `mN_ready` is never high for two consecutive cycles.

## Test plan
- Single read, M0 only, `addr`=0x0005_0010, RAM returns 0x1234_5678 one cycle after `mem_valid` -> `m0_ready` pulses once with rdata 0x1234_5678. `mem_valid` is high for exactly 2 cycles, then low for 1 (GAP).
- Both masters continuously valid for 8 transactions -> grants alternate 0,1,0,1,…. Each master gets 4 ready pulses and no two consecutive grants go to the same master.
- M1 write to unmapped 0x000F_0000, `wstrb`=4'hF, no `mem_ready` -> `m1_ready` 16 cycles after BUSY entry with rdata 0xDEAD_BEEF. `bus_err`=1, `err_addr`=0x000F_0000. A second timeout at 0x000E_0000 leaves `err_addr` unchanged.
- Pulse `err_clr` with no timeout -> `bus_err`=0, `err_addr`=0 next cycle. Assert `err_clr` in the timeout-completion cycle -> `bus_err` stays 1.
- Stray `mem_ready`=1 during IDLE/GAP with M0 valid -> no `m0_ready` until `mem_ready` arrives in BUSY.
- Assert `reset` during BUSY of an M1 read -> `mem_valid`, `m1_ready`, and `grant`=1 take reset values without waiting for a clock edge. After release, M0 and M1 tie -> M0 is granted.

Source files
------------

// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter for a single memory bus. Each grant is held to
// completion, followed by a mandatory idle (GAP) cycle. Unanswered accesses are
// ended by a timeout that returns an error word and records the address.
module bus_arbiter_2m #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        grant,
    output logic        bus_err,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_grant;
    logic        w_grant_next;
    logic [7:0]  r_cnt;
    logic        r_bus_err;
    logic [31:0] r_err_addr;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        w_busy;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_rsp_data;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_valid || m1_valid) begin
                    w_state_next = S_BUSY;
                    // On a tie the master that did not hold the last grant wins
                    if (m0_valid && m1_valid) begin
                        w_grant_next = ~r_grant;
                    end else begin
                        w_grant_next = m1_valid;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    w_done       = 1'b1;
                    w_state_next = S_GAP;
                end else if (r_cnt == CNT_LAST) begin
                    w_done       = 1'b1;
                    w_timeout    = 1'b1;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_busy     = (r_state == S_BUSY);
    assign w_rsp_data = mem_ready ? mem_rdata : ERR_RDATA;

    assign mem_valid = w_busy;
    assign mem_instr = w_busy & (r_grant ? m1_instr : m0_instr);
    assign mem_addr  = w_busy ? (r_grant ? m1_addr  : m0_addr)  : 32'h0;
    assign mem_wstrb = w_busy ? (r_grant ? m1_wstrb : m0_wstrb) : 4'h0;
    assign mem_wdata = w_busy ? (r_grant ? m1_wdata : m0_wdata) : 32'h0;

    assign m0_ready = w_done & ~r_grant;
    assign m1_ready = w_done &  r_grant;
    assign m0_rdata = m0_ready ? w_rsp_data : r_m0_rdata;
    assign m1_rdata = m1_ready ? w_rsp_data : r_m1_rdata;

    assign grant    = r_grant;
    assign bus_err  = r_bus_err;
    assign err_addr = r_err_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b1;
            r_cnt      <= 8'd0;
            r_bus_err  <= 1'b0;
            r_err_addr <= 32'h0;
            r_m0_rdata <= 32'h0;
            r_m1_rdata <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_cnt   <= (w_busy && !w_done) ? r_cnt + 8'd1 : 8'd0;
            if (m0_ready) begin
                r_m0_rdata <= w_rsp_data;
            end
            if (m1_ready) begin
                r_m1_rdata <= w_rsp_data;
            end
            // A timeout overrides a simultaneous clear and reloads the address
            if (w_timeout) begin
                r_bus_err <= 1'b1;
                if (!r_bus_err || err_clr) begin
                    r_err_addr <= mem_addr;
                end
            end else if (err_clr) begin
                r_bus_err  <= 1'b0;
                r_err_addr <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Bench for bus_arbiter_2m: directed scenarios plus randomized request mixes,
// checked against a transaction-level model of grants, latency, data and errors.
module tb_bus_arbiter_2m;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, m0_instr, m1_instr;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        grant, bus_err, err_clr;
    logic [31:0] err_addr;

    logic [31:0] t_addr [2];
    logic [31:0] t_wdata[2];
    logic [3:0]  t_wstrb[2];
    logic        t_instr[2];

    assign m0_addr  = t_addr[0];
    assign m1_addr  = t_addr[1];
    assign m0_wdata = t_wdata[0];
    assign m1_wdata = t_wdata[1];
    assign m0_wstrb = t_wstrb[0];
    assign m1_wstrb = t_wstrb[1];
    assign m0_instr = t_instr[0];
    assign m1_instr = t_instr[1];

    always #5 clk = ~clk;

    bus_arbiter_2m #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant), .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
    );

    int tests = 0;
    int fails = 0;

    // Slave behaviour: lat = BUSY cycle in which it answers (0 = never answers)
    int          lat = 0;
    bit          stray = 1'b0;
    bit          rd_override = 1'b0;
    logic [31:0] rd_value = 32'h0;
    int          busy_cnt = 0;

    // Reference model state
    int          m_last = 1;
    bit          m_err = 1'b0;
    logic [31:0] m_err_addr = 32'h0;
    logic [31:0] m_rdata[2] = '{32'h0, 32'h0};

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        if (rd_override) return rd_value;
        return {a[15:0], a[31:16]} ^ 32'h3C3C_C3C3;
    endfunction

    always @(negedge clk) begin
        if (mem_valid) begin
            busy_cnt++;
            if (lat != 0 && busy_cnt == lat) begin
                mem_ready = 1'b1;
                mem_rdata = slave_data(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'h0;
            end
        end else begin
            busy_cnt  = 0;
            mem_ready = stray;
            mem_rdata = stray ? 32'h5A5A_A5A5 : 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < 2; i++) begin
            t_addr[i]  = $urandom;
            t_wdata[i] = $urandom;
            t_wstrb[i] = 4'($urandom_range(0, 15));
            t_instr[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Waits for one completion of master exp_m, then checks the GAP cycle.
    task automatic wait_ready(input int exp_m, input int lt, input int offset, input bit clr);
        int          exp_k;
        int          busy_seen;
        bit          seen;
        logic [31:0] exp_rd;
        exp_k     = ((lt == 0) ? TO : lt) + offset;
        exp_rd    = (lt == 0) ? 32'hDEAD_BEEF : slave_data(t_addr[exp_m]);
        seen      = 1'b0;
        busy_seen = 0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk); #1;
            if (mem_valid) begin
                busy_seen++;
                if (busy_seen == 1) begin
                    chk("busy_grant", grant, exp_m);
                    chk("mem_addr", mem_addr, t_addr[exp_m]);
                    chk("mem_wstrb", mem_wstrb, t_wstrb[exp_m]);
                    chk("mem_wdata", mem_wdata, t_wdata[exp_m]);
                    chk("mem_instr", mem_instr, t_instr[exp_m]);
                end
            end
            if (m0_ready || m1_ready) begin
                seen = 1'b1;
                chk("m0_ready", m0_ready, (exp_m == 0));
                chk("m1_ready", m1_ready, (exp_m == 1));
                chk("ready_cycle", k, exp_k);
                chk("rdata", (exp_m == 1) ? m1_rdata : m0_rdata, exp_rd);
                m_rdata[exp_m] = exp_rd;
                m_last         = exp_m;
                if (lt == 0) begin
                    if (!m_err || clr) m_err_addr = t_addr[exp_m];
                    m_err = 1'b1;
                end else if (clr) begin
                    m_err      = 1'b0;
                    m_err_addr = 32'h0;
                end
                if (exp_m == 0) m0_valid = 1'b0;
                else            m1_valid = 1'b0;
                if (clr) err_clr = 1'b1;
            end
        end
        chk("ready_seen", seen, 1'b1);
        chk("busy_cycles", busy_seen, exp_k - offset);
        @(negedge clk); #1;
        err_clr = 1'b0;
        chk("gap_mem_valid", mem_valid, 1'b0);
        chk("gap_no_ready", {m0_ready, m1_ready}, 2'b00);
        chk("gap_mem_addr", mem_addr, 32'h0);
        chk("hold_m0_rdata", m0_rdata, m_rdata[0]);
        chk("hold_m1_rdata", m1_rdata, m_rdata[1]);
        chk("gap_grant", grant, exp_m);
        chk("bus_err", bus_err, m_err);
        chk("err_addr", err_addr, m_err_addr);
    endtask

    // One request round; with both masters valid the loser is served next.
    task automatic do_txn(input bit v0, input bit v1, input int lat_a, input int lat_b, input bit clr);
        int first;
        first = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
        @(negedge clk); #1;
        lat      = lat_a;
        m0_valid = v0;
        m1_valid = v1;
        #1;
        chk("idle_no_ready", {m0_ready, m1_ready}, 2'b00);
        chk("idle_no_valid", mem_valid, 1'b0);
        wait_ready(first, lat_a, 0, clr);
        if (v0 && v1) begin
            lat = lat_b;
            wait_ready(1 - first, lat_b, 1, 1'b0);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); #1;
        err_clr = 1'b1;
        @(negedge clk); #1;
        err_clr    = 1'b0;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
        chk("clr_bus_err", bus_err, 1'b0);
        chk("clr_err_addr", err_addr, 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
        err_clr  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_addr[i]  = 32'h0;
            t_wdata[i] = 32'h0;
            t_wstrb[i] = 4'h0;
            t_instr[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_ready", {m0_ready, m1_ready}, 2'b00);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_grant", grant, 1'b1);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_err_addr", err_addr, 32'h0);
        reset = 1'b0;

        // Single M0 read answered in the second BUSY cycle
        t_addr[0]   = 32'h0005_0010;
        rd_override = 1'b1;
        rd_value    = 32'h1234_5678;
        do_txn(1'b1, 1'b0, 2, 0, 1'b0);
        rd_override = 1'b0;

        // Both masters contending: grants must alternate
        for (int i = 0; i < 4; i++) begin
            randomize_fields();
            do_txn(1'b1, 1'b1, 2, 2, 1'b0);
        end

        // Timeouts on unmapped writes; second keeps the first address
        t_addr[1]  = 32'h000F_0000;
        t_wstrb[1] = 4'hF;
        do_txn(1'b0, 1'b1, 0, 0, 1'b0);
        t_addr[1] = 32'h000E_0000;
        do_txn(1'b0, 1'b1, 0, 0, 1'b0);

        // Clear coinciding with a timeout: flag stays set, address reloads
        t_addr[0] = 32'h000D_0000;
        do_txn(1'b1, 1'b0, 0, 0, 1'b1);
        pulse_clr();

        // Stray mem_ready outside BUSY must not complete anything
        stray = 1'b1;
        randomize_fields();
        do_txn(1'b1, 1'b0, 3, 0, 1'b0);
        stray = 1'b0;

        for (int i = 0; i < 24; i++) begin
            int r;
            randomize_fields();
            r = $urandom_range(1, 3);
            do_txn(r[0], r[1], $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end

        // Asynchronous reset in the middle of an M1 access
        @(negedge clk); #1;
        randomize_fields();
        lat      = 0;
        m1_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_busy", mem_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_valid", mem_valid, 1'b0);
        chk("arst_m1_ready", m1_ready, 1'b0);
        chk("arst_grant", grant, 1'b1);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_m0_rdata", m0_rdata, 32'h0);
        chk("arst_m1_rdata", m1_rdata, 32'h0);
        chk("arst_bus_err", bus_err, 1'b0);
        m1_valid   = 1'b0;
        m_last     = 1;
        m_err      = 1'b0;
        m_err_addr = 32'h0;
        m_rdata[0] = 32'h0;
        m_rdata[1] = 32'h0;
        @(negedge clk); #1;
        reset = 1'b0;
        randomize_fields();
        do_txn(1'b1, 1'b1, 2, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
